// File: rtl/button_event_gen_if.sv
// Button event bus: debounced button input and enable towards the event
// generator, one-cycle event strobes and the long-press level back out.
//   enable        - event generation enable (master -> slave)
//   btn_in        - debounced button level, 1 = pressed (master -> slave)
//   press_pulse   - one-cycle strobe on an accepted press (slave -> master)
//   release_pulse - one-cycle strobe on release of an accepted press
//   repeat_pulse  - one-cycle strobe per auto-repeat interval
//   long_press    - level, high while the hold is past the long-press time
//   flap          - press_pulse OR repeat_pulse
interface button_event_gen_if;
  logic enable;
  logic btn_in;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic long_press;
  logic flap;

  modport master (
    output enable,
    output btn_in,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  long_press,
    input  flap
  );

  modport slave (
    input  enable,
    input  btn_in,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output long_press,
    output flap
  );
endinterface

// File: rtl/button_event_gen.sv
// Turns the debounced button level into one-cycle game events: press,
// release, long-press level and auto-repeat, plus a combined flap strobe.
//   clk    - system clock
//   resetn - synchronous active-low reset
//   bus    - button_event_gen_if.slave (enable/btn_in in, events out);
//            all event outputs are registered
module button_event_gen #(
  parameter int unsigned LONG_CYCLES   = 5000000,
  parameter int unsigned REPEAT_CYCLES = 2500000,
  parameter int unsigned REPEAT_EN     = 1
) (
  input logic               clk,
  input logic               resetn,
  button_event_gen_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;
  localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
  localparam logic              REP_ON    = (REPEAT_EN != 0);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HELD     = 2'd1;
  localparam logic [1:0] S_REPEAT   = 2'd2;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

  logic [1:0]        state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [REP_W-1:0]  repeat_cnt, repeat_cnt_n;
  logic              press_n, release_n, repeat_n, long_n, flap_n;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_WAIT_REL;
      hold_cnt   <= '0;
      repeat_cnt <= '0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      repeat_cnt <= repeat_cnt_n;
    end
  end

  // Next-state, counter and event decode
  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    repeat_cnt_n = repeat_cnt;
    press_n      = 1'b0;
    release_n    = 1'b0;
    repeat_n     = 1'b0;

    if (!bus.enable) begin
      // Disable cancels any press silently; re-arm only after a release
      state_n      = S_WAIT_REL;
      hold_cnt_n   = '0;
      repeat_cnt_n = '0;
    end else begin
      case (state)
        S_WAIT_REL: begin
          if (!bus.btn_in) state_n = S_IDLE;
        end
        S_IDLE: begin
          if (bus.btn_in) begin
            state_n    = S_HELD;
            press_n    = 1'b1;
            hold_cnt_n = '0;
          end
        end
        S_HELD: begin
          // Release has priority over hold expiry
          if (!bus.btn_in) begin
            state_n    = S_IDLE;
            release_n  = 1'b1;
            hold_cnt_n = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_n      = S_REPEAT;
            hold_cnt_n   = '0;
            repeat_cnt_n = '0;
            repeat_n     = REP_ON;
          end else begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
          end
        end
        S_REPEAT: begin
          if (!bus.btn_in) begin
            state_n      = S_IDLE;
            release_n    = 1'b1;
            hold_cnt_n   = '0;
            repeat_cnt_n = '0;
          end else if (repeat_cnt == REP_LAST) begin
            repeat_cnt_n = '0;
            repeat_n     = REP_ON;
          end else begin
            repeat_cnt_n = repeat_cnt + REP_W'(1);
          end
        end
        default: begin
          state_n      = S_WAIT_REL;
          hold_cnt_n   = '0;
          repeat_cnt_n = '0;
        end
      endcase
    end

    long_n = (state_n == S_REPEAT);
    flap_n = press_n | repeat_n;
  end

  // Registered event outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.flap          <= 1'b0;
    end else begin
      bus.press_pulse   <= press_n;
      bus.release_pulse <= release_n;
      bus.repeat_pulse  <= repeat_n;
      bus.long_press    <= long_n;
      bus.flap          <= flap_n;
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen. Two instances share clock, reset and
// stimulus: u_dut_a with auto-repeat (REPEAT_EN=1) and u_dut_b without
// (REPEAT_EN=0); both use LONG_CYCLES=10, REPEAT_CYCLES=4.
module tb_button_event_gen;

  logic clk;
  logic resetn;
  int   n_total;
  int   n_bad;

  button_event_gen_if bus_a ();
  button_event_gen_if bus_b ();

  button_event_gen #(
    .LONG_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .REPEAT_EN    (1)
  ) u_dut_a (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_a.slave)
  );

  button_event_gen #(
    .LONG_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .REPEAT_EN    (0)
  ) u_dut_b (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic btn);
    bus_a.enable = en;
    bus_a.btn_in = btn;
    bus_b.enable = en;
    bus_b.btn_in = btn;
  endtask

  // Advance one clock, then check both instances. Instance B never repeats,
  // so its flap is the press strobe alone.
  task automatic tick_check(input string tag, input logic ep, input logic er,
                            input logic erep, input logic el);
    @(posedge clk);
    #1;
    check_eq({tag, "_a_press"},   bus_a.press_pulse,   ep);
    check_eq({tag, "_a_release"}, bus_a.release_pulse, er);
    check_eq({tag, "_a_repeat"},  bus_a.repeat_pulse,  erep);
    check_eq({tag, "_a_long"},    bus_a.long_press,    el);
    check_eq({tag, "_a_flap"},    bus_a.flap,          ep | erep);
    check_eq({tag, "_b_press"},   bus_b.press_pulse,   ep);
    check_eq({tag, "_b_release"}, bus_b.release_pulse, er);
    check_eq({tag, "_b_repeat"},  bus_b.repeat_pulse,  1'b0);
    check_eq({tag, "_b_long"},    bus_b.long_press,    el);
    check_eq({tag, "_b_flap"},    bus_b.flap,          ep);
  endtask

  // Cycle k of a continuous hold that started at edge t0 (k=0)
  task automatic hold_cycle(input string tag, input int k);
    logic ep, erep, el;
    ep   = (k == 0);
    el   = (k >= 10);
    erep = (k >= 10) && (((k - 10) % 4) == 0);
    tick_check($sformatf("%s_k%0d", tag, k), ep, 1'b0, erep, el);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    resetn  = 1'b0;
    drive(1'b1, 1'b0);

    // Reset state
    tick_check("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick_check("wait2idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Short press: three cycles held
    drive(1'b1, 1'b1);
    tick_check("t1_press", 1'b1, 1'b0, 1'b0, 1'b0);
    tick_check("t1_h1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("t1_h2", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tick_check("t1_rel", 1'b0, 1'b1, 1'b0, 1'b0);
    tick_check("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Long hold of 25 cycles: repeats at 10,14,18,22 then release
    drive(1'b1, 1'b1);
    for (int k = 0; k < 25; k++) hold_cycle("t2", k);
    drive(1'b1, 1'b0);
    tick_check("t2_rel", 1'b0, 1'b1, 1'b0, 1'b0);
    tick_check("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Release on the same edge as hold expiry: release wins
    drive(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) hold_cycle("t3", k);
    drive(1'b1, 1'b0);
    tick_check("t3_rel", 1'b0, 1'b1, 1'b0, 1'b0);
    tick_check("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Disable mid-repeat: long_press drops, no release, no re-press while held
    drive(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) hold_cycle("t4", k);
    drive(1'b0, 1'b1);
    tick_check("t4_dis", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick_check($sformatf("t4_held%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tick_check("t4_up", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    tick_check("t4_press", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tick_check("t4_rel", 1'b0, 1'b1, 1'b0, 1'b0);

    // Button held through reset, then enable toggled while held
    drive(1'b1, 1'b1);
    resetn = 1'b0;
    tick_check("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) tick_check($sformatf("t5_held%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1);
    tick_check("t5_en0", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    tick_check("t5_en1a", 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("t5_en1b", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tick_check("t5_up", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    tick_check("t5_press", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tick_check("t5_rel", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-repeat with button still held
    drive(1'b1, 1'b1);
    for (int k = 0; k < 14; k++) hold_cycle("t6", k);
    resetn = 1'b0;
    tick_check("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) tick_check($sformatf("t6_held%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tick_check("t6_up", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    tick_check("t6_press", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tick_check("t6_rel", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
